// File: rtl/wave_pkg.sv
// Shared types and constants for the wave controller and the bloon path engines.
package wave_pkg;

    localparam int TICK_SHIFT = 20;

    typedef enum logic [1:0] {
        SLOT_INACTIVE,
        SLOT_LIVE,
        SLOT_POPPED,
        SLOT_ESCAPED
    } slot_state_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_CLEAR,
        ST_OVER
    } wave_state_t;

endpackage

// File: rtl/wave_controller_if.sv
// Bus between the game logic / path engines and the wave controller.
interface wave_controller_if #(
    parameter int NUM_BLOONS = 8,
    parameter int ST_W       = 128
);
    logic                       start_wave;
    logic                       pause;
    logic [NUM_BLOONS-1:0]      pop;
    logic [NUM_BLOONS-1:0]      lost_life;
    logic                       path_reset;
    logic [NUM_BLOONS-1:0]      bloon_hold;
    logic                       bloon_run;
    logic [NUM_BLOONS*ST_W-1:0] starting_time;
    logic [7:0]                 lives;
    logic [7:0]                 wave_num;
    logic                       wave_active;
    logic                       wave_done;
    logic                       game_over;

    modport master (
        output start_wave, pause, pop, lost_life,
        input  path_reset, bloon_hold, bloon_run, starting_time,
               lives, wave_num, wave_active, wave_done, game_over
    );

    modport slave (
        input  start_wave, pause, pop, lost_life,
        output path_reset, bloon_hold, bloon_run, starting_time,
               lives, wave_num, wave_active, wave_done, game_over
    );
endinterface

// File: rtl/wave_controller_esc_counter.sv
// Counts escaping live slots this cycle, clamped so the lives register never underflows.
module esc_counter #(
    parameter int NUM_BLOONS = 8
) (
    input  logic [NUM_BLOONS-1:0] i_edge,
    input  logic [NUM_BLOONS-1:0] i_live,
    input  logic [7:0]            i_lives,
    output logic [7:0]            o_dec
);
    logic [4:0] w_count;

    always_comb begin
        // NOTE: blocking assignments here are intentional; the accumulator is evaluated in order within one pass.
        w_count = '0;
        for (int i = 0; i < NUM_BLOONS; i++) begin
            w_count = w_count + {4'd0, i_edge[i] & i_live[i]};
        end
        o_dec = ({3'd0, w_count} > i_lives) ? i_lives : {3'd0, w_count};
    end
endmodule

// File: rtl/wave_controller.sv
// Launches waves of bloon slots, tracks pops/escapes, lives, wave clear and game over.
module wave_controller
    import wave_pkg::*;
#(
    parameter int NUM_BLOONS  = 8,
    parameter int SPAWN_GAP   = 32,
    parameter int START_LIVES = 20,
    parameter int ST_W        = 128
) (
    input logic              Clk,
    input logic              reset,
    wave_controller_if.slave bus
);
    wave_state_t           r_state;
    wave_state_t           w_state_next;
    slot_state_t           r_slot [NUM_BLOONS];
    logic [7:0]            r_lives;
    logic [7:0]            r_wave_num;
    logic [NUM_BLOONS-1:0] r_lost_d;
    logic [NUM_BLOONS-1:0] w_live;
    logic [NUM_BLOONS-1:0] w_esc;
    logic [NUM_BLOONS-1:0] w_pop;
    logic [7:0]            w_dec;
    logic [4:0]            w_wave_size;
    logic                  w_in_run;

    always_comb begin
        for (int i = 0; i < NUM_BLOONS; i++) begin
            w_live[i] = (r_slot[i] == SLOT_LIVE);
        end
    end

    // wave_num has already been bumped on entry to ARM, so it is the size of this wave.
    assign w_wave_size = (r_wave_num >= 8'(NUM_BLOONS)) ? 5'(NUM_BLOONS) : r_wave_num[4:0];
    assign w_in_run    = (r_state == ST_RUN);
    assign w_esc       = bus.lost_life & ~r_lost_d & w_live & {NUM_BLOONS{w_in_run & ~bus.pause}};
    assign w_pop       = bus.pop & w_live & {NUM_BLOONS{w_in_run}};

    esc_counter #(.NUM_BLOONS(NUM_BLOONS)) u_esc_counter (
        .i_edge  (w_esc),
        .i_live  (w_live),
        .i_lives (r_lives),
        .o_dec   (w_dec)
    );

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a latch behind.
        w_state_next    = r_state;
        bus.path_reset  = 1'b1;
        bus.bloon_run   = 1'b0;
        bus.bloon_hold  = ~w_live;
        bus.wave_active = 1'b0;
        bus.wave_done   = 1'b0;
        bus.game_over   = 1'b0;
        unique case (r_state)
            ST_IDLE: if (bus.start_wave) w_state_next = ST_ARM;
            ST_ARM: begin
                bus.wave_active = 1'b1;
                w_state_next    = ST_RUN;
            end
            ST_RUN: begin
                bus.path_reset  = 1'b0;
                bus.bloon_run   = ~bus.pause;
                bus.wave_active = 1'b1;
                if (r_lives == 8'd0)    w_state_next = ST_OVER;
                else if (w_live == '0)  w_state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                bus.wave_done  = 1'b1;
                bus.bloon_hold = '1;
                w_state_next   = ST_IDLE;
            end
            ST_OVER: begin
                bus.game_over  = 1'b1;
                bus.bloon_hold = '1;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            r_state    <= ST_IDLE;
            r_lives    <= 8'(START_LIVES);
            r_wave_num <= '0;
            r_lost_d   <= '0;
            // NOTE: the slot array is a handful of flops driving bloon_hold, so it is reset like any other register.
            for (int i = 0; i < NUM_BLOONS; i++) r_slot[i] <= SLOT_INACTIVE;
        end else begin
            r_state  <= w_state_next;
            r_lives  <= r_lives - w_dec;
            r_lost_d <= (r_state == ST_ARM) ? '0 : bus.lost_life;
            if (r_state == ST_IDLE && bus.start_wave && r_wave_num != 8'hFF)
                r_wave_num <= r_wave_num + 8'd1;
            for (int i = 0; i < NUM_BLOONS; i++) begin
                if (r_state == ST_ARM)
                    r_slot[i] <= (5'(i) < w_wave_size) ? SLOT_LIVE : SLOT_INACTIVE;
                else if (w_esc[i])
                    r_slot[i] <= SLOT_ESCAPED;
                else if (w_pop[i])
                    r_slot[i] <= SLOT_POPPED;
            end
        end
    end

    always_comb begin
        bus.starting_time = '0;
        for (int i = 0; i < NUM_BLOONS; i++) begin
            bus.starting_time[i*ST_W +: ST_W] = ST_W'(i * SPAWN_GAP);
        end
    end

    assign bus.lives    = r_lives;
    assign bus.wave_num = r_wave_num;
endmodule

// File: tb/tb_wave_controller.sv
// Directed bench for wave_controller with a per-cycle behavioural model and literal spot checks.
module tb_wave_controller;
    localparam int N  = 8;
    localparam int SW = 128;

    // Model phases and slot conditions, kept as plain integers.
    localparam int P_IDLE = 0, P_ARM = 1, P_RUN = 2, P_CLEAR = 3, P_OVER = 4;
    localparam int S_OFF = 0, S_LIVE = 1, S_POP = 2, S_ESC = 3;

    logic Clk = 1'b0;
    logic reset;

    wave_controller_if #(.NUM_BLOONS(N), .ST_W(SW)) bus ();

    wave_controller #(
        .NUM_BLOONS  (N),
        .SPAWN_GAP   (32),
        .START_LIVES (20),
        .ST_W        (SW)
    ) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       m_phase, m_lives, m_wave, m_hits, m_old_phase, m_size;
    int       m_slot [N];
    bit [N-1:0] m_prev;
    bit       m_valid = 1'b0;
    bit       m_any_live;

    always @(posedge Clk) begin
        if (reset) begin
            m_phase = P_IDLE;
            m_lives = 20;
            m_wave  = 0;
            m_prev  = '0;
            for (int i = 0; i < N; i++) m_slot[i] = S_OFF;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_old_phase = m_phase;
            m_any_live  = 1'b0;
            for (int i = 0; i < N; i++) if (m_slot[i] == S_LIVE) m_any_live = 1'b1;
            case (m_old_phase)
                P_IDLE: if (bus.start_wave) begin
                    m_wave  = (m_wave < 255) ? m_wave + 1 : 255;
                    m_phase = P_ARM;
                end
                P_ARM: begin
                    m_size = (m_wave < N) ? m_wave : N;
                    for (int i = 0; i < N; i++) m_slot[i] = (i < m_size) ? S_LIVE : S_OFF;
                    m_phase = P_RUN;
                end
                P_RUN: begin
                    if (m_lives == 0)     m_phase = P_OVER;
                    else if (!m_any_live) m_phase = P_CLEAR;
                    m_hits = 0;
                    for (int i = 0; i < N; i++) begin
                        if (m_slot[i] == S_LIVE) begin
                            if (bus.lost_life[i] && !m_prev[i] && !bus.pause) begin
                                m_slot[i] = S_ESC;
                                m_hits++;
                            end else if (bus.pop[i]) begin
                                m_slot[i] = S_POP;
                            end
                        end
                    end
                    m_lives = (m_hits > m_lives) ? 0 : m_lives - m_hits;
                end
                P_CLEAR: m_phase = P_IDLE;
                default: ;
            endcase
            m_prev = (m_old_phase == P_ARM) ? '0 : bus.lost_life;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [N-1:0] exp_hold;

    always @(negedge Clk) begin
        if (m_valid) begin
            for (int i = 0; i < N; i++)
                exp_hold[i] = !(m_slot[i] == S_LIVE && m_phase != P_CLEAR && m_phase != P_OVER);
            check("path_reset",  bus.path_reset,  m_phase != P_RUN);
            check("bloon_run",   bus.bloon_run,   m_phase == P_RUN && !bus.pause);
            check("bloon_hold",  bus.bloon_hold,  exp_hold);
            check("lives",       bus.lives,       m_lives);
            check("wave_num",    bus.wave_num,    m_wave);
            check("wave_active", bus.wave_active, m_phase == P_ARM || m_phase == P_RUN);
            check("wave_done",   bus.wave_done,   m_phase == P_CLEAR);
            check("game_over",   bus.game_over,   m_phase == P_OVER);
            for (int i = 0; i < N; i++)
                check("starting_time", bus.starting_time[i*SW +: SW], 128'(i * 32));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic launch();
        bus.start_wave = 1'b1;
        tick(1);
        bus.start_wave = 1'b0;
        tick(1);
    endtask

    task automatic end_wave(input logic [N-1:0] mask);
        bus.pop = mask;
        tick(1);
        bus.pop = '0;
        tick(2);
    endtask

    initial begin
        reset          = 1'b1;
        bus.start_wave = 1'b0;
        bus.pause      = 1'b0;
        bus.pop        = '0;
        bus.lost_life  = '0;
        tick(2);
        reset = 1'b0;
        check("rst_lives",      bus.lives,      8'd20);
        check("rst_wave_num",   bus.wave_num,   8'd0);
        check("rst_path_reset", bus.path_reset, 1'b1);
        check("rst_hold",       bus.bloon_hold, 8'hFF);
        check("rst_game_over",  bus.game_over,  1'b0);

        // Wave 1: one slot, popped.
        bus.start_wave = 1'b1;
        tick(1);
        bus.start_wave = 1'b0;
        check("arm_path_reset", bus.path_reset, 1'b1);
        check("arm_wave_num",   bus.wave_num,   8'd1);
        tick(1);
        check("run_hold",   bus.bloon_hold, 8'hFE);
        check("run_run",    bus.bloon_run,  1'b1);
        check("run_st3",    bus.starting_time[3*SW +: SW], 128'd96);
        bus.pop = 8'h01;
        tick(1);
        bus.pop = '0;
        check("pop_hold", bus.bloon_hold, 8'hFF);
        check("pop_done_early", bus.wave_done, 1'b0);
        tick(1);
        check("w1_done", bus.wave_done, 1'b1);
        tick(1);
        check("w1_idle_done", bus.wave_done, 1'b0);
        check("w1_lives", bus.lives, 8'd20);

        // Wave 2: two slots, popped.
        launch();
        end_wave(8'h03);

        // Wave 3: long-high escape costs one life.
        launch();
        check("w3_hold", bus.bloon_hold, 8'hF8);
        bus.lost_life = 8'h02;
        tick(1000);
        check("w3_lives_once", bus.lives, 8'd19);
        bus.lost_life = '0;
        bus.pop = 8'h05;
        tick(1);
        bus.pop = '0;
        tick(1);
        check("w3_done", bus.wave_done, 1'b1);
        tick(1);
        check("w3_lives", bus.lives, 8'd19);

        // Wave 4: pause behaviour, then same-cycle pop and escape.
        launch();
        bus.pause = 1'b1;
        tick(1);
        check("pause_run", bus.bloon_run, 1'b0);
        bus.pop = 8'h01;
        tick(1);
        bus.pop = '0;
        check("pause_pop_hold", bus.bloon_hold, 8'hF1);
        bus.lost_life = 8'h02;
        tick(2);
        check("pause_esc_lives", bus.lives, 8'd19);
        bus.pause = 1'b0;
        tick(1);
        check("unpause_lives", bus.lives, 8'd19);
        bus.lost_life = '0;
        tick(1);
        bus.pop       = 8'h02;
        bus.lost_life = 8'h02;
        tick(1);
        bus.pop = '0;
        check("popesc_lives", bus.lives, 8'd18);
        check("popesc_hold",  bus.bloon_hold, 8'hF3);
        bus.lost_life = '0;
        end_wave(8'h0C);
        check("w4_wave_num", bus.wave_num, 8'd4);

        // Wave 5: reset in the middle of RUN.
        launch();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_rst_lives",  bus.lives,       8'd20);
        check("mid_rst_wave",   bus.wave_num,    8'd0);
        check("mid_rst_hold",   bus.bloon_hold,  8'hFF);
        check("mid_rst_active", bus.wave_active, 1'b0);

        // Drain lives: waves of K=1..5 with every slot escaping at once.
        for (int w = 1; w <= 5; w++) begin
            logic [31:0] mask32;
            mask32 = (32'd1 << w) - 32'd1;
            launch();
            bus.lost_life = mask32[N-1:0];
            tick(1);
            bus.lost_life = '0;
            tick(2);
        end
        check("drain_lives", bus.lives, 8'd5);

        // Wave 6: six escapes against five lives saturates at zero.
        launch();
        check("w6_hold", bus.bloon_hold, 8'hC0);
        bus.lost_life = 8'h3F;
        tick(1);
        bus.lost_life = '0;
        check("sat_lives", bus.lives, 8'd0);
        tick(1);
        check("over_flag", bus.game_over,  1'b1);
        check("over_hold", bus.bloon_hold, 8'hFF);
        bus.start_wave = 1'b1;
        tick(1);
        bus.start_wave = 1'b0;
        tick(2);
        check("over_wave_num", bus.wave_num,  8'd6);
        check("over_sticky",   bus.game_over, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
